fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one Fifo write port (data_inen/data_in, gated by fifo_full) between NUM_REQ producers. It grants bursts of up to MAX_BURST words per producer and acks each accepted word. It never writes while fifo_full=1. It sits directly in front of the Fifo instance; the Fifo read side is untouched.

---
 rtl/fifo_wr_arbiter_pkg.sv | 25 ++
 rtl/fifo_wr_arbiter_if.sv | 39 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// ============================================================================
//  Module   : fifo_arb_pkg
//  Brief    : Shared types and constants for the Fifo write-port arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam logic [15:0] c_STALL_SAT = 16'hFFFF;
    localparam int          c_BURST_W   = 4;

    // Owner index width; never below one bit so NUM_REQ=1 corner still elaborates.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
// ============================================================================
//  Module   : fifo_wr_arbiter_if
//  Brief    : Producer request bus plus Fifo write side, shared by arbiter and
//             its environment (slave = arbiter, master = producers/Fifo).
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8
);
    import fifo_arb_pkg::*;

    localparam int c_ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DATA_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           ack;
    logic                         fifo_full;
    logic                         data_inen;
    logic [DATA_SIZE-1:0]         data_in;
    logic [c_ID_W-1:0]            owner;
    logic                         busy;
    logic [15:0]                  stall_cycles;

    modport master (
        output req, req_data, fifo_full,
        input  ack, data_inen, data_in, owner, busy, stall_cycles
    );

    modport slave (
        input  req, req_data, fifo_full,
        output ack, data_inen, data_in, owner, busy, stall_cycles
    );

endinterface

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ============================================================================
//  Module   : rr_pick
//  Brief    : Combinational round-robin picker: first set request scanning
//             from last+1 with wrap-around.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [ID_W-1:0]    i_last,
    output logic                    o_found,
    output logic [ID_W-1:0]         o_idx
);

    logic [ID_W-1:0] w_cand;

    // Scan farthest-first so the nearest match after i_last overwrites the rest.
    always_comb begin
        o_found = |i_req;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = ID_W'((int'(i_last) + k) % NUM_REQ);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Brief    : Round-robin burst arbiter sharing one Fifo write port between
//             NUM_REQ producers. Optional stall counter: FIFO_ARB_STATS_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    fifo_wr_arbiter_if.slave bus
);
    import fifo_arb_pkg::*;

    localparam int                   c_ID_W      = id_width(NUM_REQ);
    localparam logic [c_BURST_W-1:0] c_MAX_BURST = c_BURST_W'(MAX_BURST);
    localparam logic [c_BURST_W-1:0] c_BURST_ONE = c_BURST_W'(1);
    localparam logic [c_ID_W-1:0]    c_LAST_RST  = c_ID_W'(NUM_REQ - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [c_ID_W-1:0]    r_owner;
    logic [c_ID_W-1:0]    w_owner_nxt;
    logic [c_ID_W-1:0]    r_last;
    logic [c_ID_W-1:0]    w_last_nxt;
    logic [c_BURST_W-1:0] r_burst_cnt;
    logic [c_BURST_W-1:0] w_burst_nxt;

    logic                 w_pick_found;
    logic [c_ID_W-1:0]    w_pick_idx;
    logic                 w_req_own;
    logic                 w_wr;
    logic [NUM_REQ-1:0]   w_ack;
    logic [DATA_SIZE-1:0] w_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (c_ID_W)
    ) u_rr_pick (
        .i_req   (bus.req),
        .i_last  (r_last),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    assign w_req_own = bus.req[r_owner];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_last      <= c_LAST_RST;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_burst_nxt = r_burst_cnt;
        w_wr        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_pick_idx;
                    w_burst_nxt = '0;
                end
            end
            GRANT: begin
                if (!w_req_own) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_owner;
                end else if (!bus.fifo_full) begin
                    w_wr        = 1'b1;
                    w_burst_nxt = r_burst_cnt + c_BURST_ONE;
                    if ((r_burst_cnt + c_BURST_ONE) == c_MAX_BURST) begin
                        w_state_nxt = IDLE;
                        w_last_nxt  = r_owner;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Write path is purely combinational so the word lands on the acking edge.
    always_comb begin
        w_ack  = '0;
        w_data = '0;
        if (w_wr) begin
            w_ack  = NUM_REQ'(1) << r_owner;
            w_data = bus.req_data[int'(r_owner)*DATA_SIZE +: DATA_SIZE];
        end
    end

    assign bus.ack       = w_ack;
    assign bus.data_inen = w_wr;
    assign bus.data_in   = w_data;
    assign bus.owner     = r_owner;
    assign bus.busy      = (r_state == GRANT);

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if ((r_state == GRANT) && w_req_own && bus.fifo_full
                     && (r_stall_cycles != c_STALL_SAT)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`else
    assign bus.stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Brief    : Directed self-checking bench for fifo_wr_arbiter (4 x 8-bit, burst 4).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_SIZE(8)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_SIZE (8),
        .MAX_BURST (4)
    ) u_dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req       = '0;
        bus.fifo_full = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] t2_data [9] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'hA4, 8'hA5, 8'h00};
    int         t3_seq  [4] = '{0, 1, 3, 0};
    logic [3:0] exp_ack;
    logic       exp_inen;
    logic       exp_busy;
    logic [15:0] exp_stall;
    int         n_words;

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        n_checks      = 0;
        n_errors      = 0;
        bus.req       = 4'b1111;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;

        // Reset held with every producer requesting
        repeat (10) @(negedge clk);
        #1;
        check("rst_busy",  32'(bus.busy),         32'h0);
        check("rst_inen",  32'(bus.data_inen),    32'h0);
        check("rst_ack",   32'(bus.ack),          32'h0);
        check("rst_data",  32'(bus.data_in),      32'h0);
        check("rst_owner", 32'(bus.owner),        32'h0);
        check("rst_stall", 32'(bus.stall_cycles), 32'h0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h5A};
        #1;
        check("rel_idle_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        #1;
        check("rel_owner", 32'(bus.owner),   32'h0);
        check("rel_busy",  32'(bus.busy),    32'h1);
        check("rel_ack",   32'(bus.ack),     32'h1);
        check("rel_data",  32'(bus.data_in), 32'h5A);

        // Single producer 2, words advance on ack
        do_reset();
        n_words = 0;
        for (int c = 0; c < 9; c++) begin
            bus.req          = (n_words < 6) ? 4'b0100 : 4'b0000;
            bus.req_data     = '0;
            bus.req_data[23:16] = 8'(8'hA0 + n_words);
            #1;
            exp_inen = (t2_data[c] != 8'h00);
            check("sp_inen", 32'(bus.data_inen), 32'(exp_inen));
            check("sp_data", 32'(bus.data_in),   32'(t2_data[c]));
            check("sp_ack",  32'(bus.ack),       exp_inen ? 32'h4 : 32'h0);
            if (exp_inen) check("sp_owner", 32'(bus.owner), 32'h2);
            if (bus.ack[2]) n_words++;
            @(negedge clk);
        end

        // Round-robin over 0,1,3 with 2 idle
        do_reset();
        bus.req      = 4'b1011;
        bus.req_data = {8'h43, 8'h42, 8'h41, 8'h40};
        for (int c = 0; c < 20; c++) begin
            #1;
            exp_ack = ((c % 5) == 0) ? 4'b0000 : (4'b0001 << t3_seq[c / 5]);
            check("rr_ack", 32'(bus.ack), 32'(exp_ack));
            if ((c % 5) != 0) begin
                check("rr_data", 32'(bus.data_in), 32'(8'h40 + t3_seq[c / 5]));
            end
            @(negedge clk);
        end

        // Full stall on owner 1 after 2 words
        do_reset();
        bus.req      = 4'b0010;
        bus.req_data = {8'h00, 8'h00, 8'h77, 8'h00};
        for (int c = 0; c < 11; c++) begin
            bus.fifo_full = (c >= 3 && c <= 7);
            #1;
            exp_inen = (c == 1 || c == 2 || c == 8 || c == 9);
            exp_busy = (c >= 1 && c <= 9);
            check("fs_inen", 32'(bus.data_inen), 32'(exp_inen));
            check("fs_busy", 32'(bus.busy),      32'(exp_busy));
            if (c == 3) check("fs_owner", 32'(bus.owner), 32'h1);
            if (c == 8) check("fs_data",  32'(bus.data_in), 32'h77);
            @(negedge clk);
        end
`ifdef FIFO_ARB_STATS_EN
        exp_stall = 16'd5;
`else
        exp_stall = 16'd0;
`endif
        #1;
        check("fs_stall", 32'(bus.stall_cycles), 32'(exp_stall));

        // Early drop by owner 3 with requester 0 waiting
        do_reset();
        bus.req      = 4'b1000;
        bus.req_data = {8'hD3, 8'h00, 8'h00, 8'hD0};
        #1;
        check("ed_c0_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        #1;
        check("ed_c1_ack",   32'(bus.ack),   32'h8);
        check("ed_c1_owner", 32'(bus.owner), 32'h3);
        @(negedge clk);
        bus.req = 4'b0001;
        #1;
        check("ed_c2_ack",  32'(bus.ack),       32'h0);
        check("ed_c2_inen", 32'(bus.data_inen), 32'h0);
        @(negedge clk);
        #1;
        check("ed_c3_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        #1;
        check("ed_c4_owner", 32'(bus.owner),   32'h0);
        check("ed_c4_ack",   32'(bus.ack),     32'h1);
        check("ed_c4_data",  32'(bus.data_in), 32'hD0);

        // Asynchronous reset in the middle of a burst
        do_reset();
        bus.req      = 4'b0001;
        bus.req_data = {8'h00, 8'h00, 8'h00, 8'h99};
        repeat (2) @(negedge clk);
        #1;
        check("mr_ack_pre", 32'(bus.ack), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mr_ack",  32'(bus.ack),       32'h0);
        check("mr_inen", 32'(bus.data_inen), 32'h0);
        check("mr_data", 32'(bus.data_in),   32'h0);
        check("mr_busy", 32'(bus.busy),      32'h0);
        repeat (2) @(negedge clk);
        bus.req = 4'b1111;
        rst_n   = 1'b1;
        #1;
        check("mr_rel_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        #1;
        check("mr_rel_owner", 32'(bus.owner), 32'h0);
        check("mr_rel_ack",   32'(bus.ack),   32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
